// File: rtl/exe_stage_unit.sv
// exe_stage_unit: execute stage of the ARM-subset pipeline (operand 2, ALU, NZCV, branch target, EXE/MEM register).
// Define EXE_FWD_EN to compile in the sel_src1/sel_src2 operand forwarding muxes.
module exe_stage_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             freeze,
   input  logic             WB_EN_IN,
   input  logic             MEM_R_EN_IN,
   input  logic             MEM_W_EN_IN,
   input  logic             B_IN,
   input  logic             S_IN,
   input  logic [3:0]       EXE_CMD_IN,
   input  logic [WIDTH-1:0] PC_IN,
   input  logic [WIDTH-1:0] Val_Rn_IN,
   input  logic [WIDTH-1:0] Val_Rm_IN,
   input  logic             imm_IN,
   input  logic [11:0]      Shift_operand_IN,
   input  logic [23:0]      Signed_imm_24_IN,
   input  logic [3:0]       Dest_IN,
   output logic             Br_taken,
   output logic [WIDTH-1:0] Br_addr,
   output logic [3:0]       SR,
   output logic             WB_EN,
   output logic             MEM_R_EN,
   output logic             MEM_W_EN,
   output logic [WIDTH-1:0] ALU_Res,
   output logic [WIDTH-1:0] Val_Rm,
   output logic [3:0]       Dest
`ifdef EXE_FWD_EN
   ,
   input  logic [1:0]       sel_src1,
   input  logic [1:0]       sel_src2,
   input  logic [WIDTH-1:0] MEM_fwd,
   input  logic [WIDTH-1:0] WB_fwd
`endif
);

   typedef enum logic [3:0] {
      CMD_MOV = 4'b0001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000,
      CMD_MVN = 4'b1001
   } alu_cmd_e;

   function automatic logic [WIDTH-1:0] ror32(input logic [WIDTH-1:0] x, input logic [4:0] r);
      return (x >> r) | (x << (6'd32 - {1'b0, r}));
   endfunction

   logic [WIDTH-1:0] src1, src2;

`ifdef EXE_FWD_EN
   // Encoding 11 is reserved and falls back to the ID-stage value.
   always_comb begin
      case (sel_src1)
         2'b01:   src1 = MEM_fwd;
         2'b10:   src1 = WB_fwd;
         default: src1 = Val_Rn_IN;
      endcase
      case (sel_src2)
         2'b01:   src2 = MEM_fwd;
         2'b10:   src2 = WB_fwd;
         default: src2 = Val_Rm_IN;
      endcase
   end
`else
   assign src1 = Val_Rn_IN;
   assign src2 = Val_Rm_IN;
`endif

   assign Br_taken = B_IN & ~flush;
   assign Br_addr  = PC_IN + {{6{Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

   logic [4:0]       sh_amt;
   logic [WIDTH-1:0] val2;

   assign sh_amt = Shift_operand_IN[11:7];

   always_comb begin
      val2 = '0;
      if (MEM_R_EN_IN || MEM_W_EN_IN) begin
         val2 = {20'b0, Shift_operand_IN};
      end else if (imm_IN) begin
         val2 = ror32({24'b0, Shift_operand_IN[7:0]}, {Shift_operand_IN[11:8], 1'b0});
      end else begin
         case (Shift_operand_IN[6:5])
            2'b00:   val2 = src2 << sh_amt;
            2'b01:   val2 = src2 >> sh_amt;
            2'b10:   val2 = $signed(src2) >>> sh_amt;
            default: val2 = ror32(src2, sh_amt);
         endcase
      end
   end

   alu_cmd_e       cmd;
   logic [WIDTH:0] sum;
   logic [WIDTH-1:0] res;
   logic           arith, is_sub, flags_en, v_flag;
   logic [3:0]     sr_d, sr_q;

   assign cmd = alu_cmd_e'(EXE_CMD_IN);

   // Subtracts are done as A + ~B + carry-in so bit 32 is the ARM "no borrow" carry.
   always_comb begin
      sum      = '0;
      res      = '0;
      arith    = 1'b0;
      is_sub   = 1'b0;
      flags_en = 1'b1;
      case (cmd)
         CMD_MOV: res = val2;
         CMD_MVN: res = ~val2;
         CMD_ADD: begin sum = {1'b0, src1} + {1'b0, val2};                   arith = 1'b1; end
         CMD_ADC: begin sum = {1'b0, src1} + {1'b0, val2} + {32'b0, sr_q[1]}; arith = 1'b1; end
         CMD_SUB: begin sum = {1'b0, src1} + {1'b0, ~val2} + 33'd1;           arith = 1'b1; is_sub = 1'b1; end
         CMD_SBC: begin sum = {1'b0, src1} + {1'b0, ~val2} + {32'b0, sr_q[1]}; arith = 1'b1; is_sub = 1'b1; end
         CMD_AND: res = src1 & val2;
         CMD_ORR: res = src1 | val2;
         CMD_EOR: res = src1 ^ val2;
         default: flags_en = 1'b0;
      endcase
      if (arith) res = sum[WIDTH-1:0];
      v_flag = ((src1[WIDTH-1] ^ val2[WIDTH-1]) == is_sub) && (res[WIDTH-1] != src1[WIDTH-1]);
      sr_d   = {res[WIDTH-1], (res == '0),
                arith ? sum[WIDTH] : sr_q[1],
                arith ? v_flag     : sr_q[0]};
   end

   logic             wb_en_q, mem_r_en_q, mem_w_en_q;
   logic [WIDTH-1:0] alu_res_q, val_rm_q;
   logic [3:0]       dest_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q       <= '0;
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         mem_w_en_q <= 1'b0;
         alu_res_q  <= '0;
         val_rm_q   <= '0;
         dest_q     <= '0;
      end else begin
         if (S_IN && !flush && !freeze && flags_en) sr_q <= sr_d;
         if (flush || !freeze) begin
            wb_en_q    <= WB_EN_IN    & ~flush;
            mem_r_en_q <= MEM_R_EN_IN & ~flush;
            mem_w_en_q <= MEM_W_EN_IN & ~flush;
            alu_res_q  <= res;
            val_rm_q   <= src2;
            dest_q     <= Dest_IN;
         end
      end
   end

   assign SR       = sr_q;
   assign WB_EN    = wb_en_q;
   assign MEM_R_EN = mem_r_en_q;
   assign MEM_W_EN = mem_w_en_q;
   assign ALU_Res  = alu_res_q;
   assign Val_Rm   = val_rm_q;
   assign Dest     = dest_q;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed-vector bench for exe_stage_unit; expected values are hand-computed.
module tb_exe_stage_unit;

   logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, freeze = 1'b0;
   logic        WB_EN_IN = 1'b0, MEM_R_EN_IN = 1'b0, MEM_W_EN_IN = 1'b0, B_IN = 1'b0, S_IN = 1'b0;
   logic [3:0]  EXE_CMD_IN = '0, Dest_IN = '0;
   logic [31:0] PC_IN = '0, Val_Rn_IN = '0, Val_Rm_IN = '0;
   logic        imm_IN = 1'b0;
   logic [11:0] Shift_operand_IN = '0;
   logic [23:0] Signed_imm_24_IN = '0;
   logic        Br_taken, WB_EN, MEM_R_EN, MEM_W_EN;
   logic [31:0] Br_addr, ALU_Res, Val_Rm;
   logic [3:0]  SR, Dest;

   int checks = 0;
   int failures = 0;

   exe_stage_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
      .B_IN(B_IN), .S_IN(S_IN), .EXE_CMD_IN(EXE_CMD_IN), .PC_IN(PC_IN),
      .Val_Rn_IN(Val_Rn_IN), .Val_Rm_IN(Val_Rm_IN), .imm_IN(imm_IN),
      .Shift_operand_IN(Shift_operand_IN), .Signed_imm_24_IN(Signed_imm_24_IN),
      .Dest_IN(Dest_IN), .Br_taken(Br_taken), .Br_addr(Br_addr), .SR(SR),
      .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest)
   );

   always #5 clk = ~clk;

   // Presents one instruction and returns 1 ns after the edge that registers it.
   task automatic issue(input logic [3:0] cmd, input logic s, input logic imm, input logic [11:0] op,
                        input logic [31:0] rn, input logic [31:0] rm, input logic [3:0] dst);
      EXE_CMD_IN = cmd; S_IN = s; imm_IN = imm; Shift_operand_IN = op;
      Val_Rn_IN = rn; Val_Rm_IN = rm; Dest_IN = dst; WB_EN_IN = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ALU_Res !== 32'h0) begin failures++; $display("FAIL reset_alu got=%h exp=%h", ALU_Res, 32'h0); end
      checks++; if (WB_EN !== 1'b0) begin failures++; $display("FAIL reset_wb got=%b exp=0", WB_EN); end
      checks++; if (SR !== 4'b0000) begin failures++; $display("FAIL reset_sr got=%b exp=0000", SR); end
      rst = 1'b1;
   endtask

   task automatic test_add_flags;
      issue(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0, 4'd3);
      checks++; if (ALU_Res !== 32'h8000_0000) begin failures++; $display("FAIL add_res got=%h exp=%h", ALU_Res, 32'h8000_0000); end
      checks++; if (SR !== 4'b1001) begin failures++; $display("FAIL add_sr got=%b exp=1001", SR); end
      checks++; if (WB_EN !== 1'b1 || Dest !== 4'd3) begin failures++; $display("FAIL add_ctl got wb=%b dest=%0d exp wb=1 dest=3", WB_EN, Dest); end
   endtask

   task automatic test_sub_adc;
      issue(4'b0100, 1'b1, 1'b1, 12'h005, 32'd5, 32'h0, 4'd1);
      checks++; if (ALU_Res !== 32'h0) begin failures++; $display("FAIL sub_res got=%h exp=0", ALU_Res); end
      checks++; if (SR !== 4'b0110) begin failures++; $display("FAIL sub_sr got=%b exp=0110", SR); end
      issue(4'b0011, 1'b0, 1'b1, 12'h001, 32'd1, 32'h0, 4'd1);
      checks++; if (ALU_Res !== 32'd3) begin failures++; $display("FAIL adc_res got=%h exp=3", ALU_Res); end
      checks++; if (SR !== 4'b0110) begin failures++; $display("FAIL adc_sr_hold got=%b exp=0110", SR); end
   endtask

   task automatic test_imm_rotate;
      issue(4'b0001, 1'b1, 1'b1, 12'h4FF, 32'h0, 32'h0, 4'd2);
      checks++; if (ALU_Res !== 32'hFF00_0000) begin failures++; $display("FAIL rot_res got=%h exp=%h", ALU_Res, 32'hFF00_0000); end
      checks++; if (SR !== 4'b1010) begin failures++; $display("FAIL mov_sr got=%b exp=1010", SR); end
      issue(4'b1001, 1'b0, 1'b1, 12'h0FF, 32'h0, 32'h0, 4'd2);
      checks++; if (ALU_Res !== 32'hFFFF_FF00) begin failures++; $display("FAIL mvn_res got=%h exp=%h", ALU_Res, 32'hFFFF_FF00); end
   endtask

   task automatic test_reg_shift;
      logic [11:0] ops [8] = '{12'h240, 12'h220, 12'h200, 12'h260, 12'h060, 12'h040, 12'h020, 12'hF80};
      logic [31:0] rms [8] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_000F, 32'h0000_000F,
                               32'h1234_5678, 32'h8000_0001, 32'h1234_5678, 32'h0000_0001};
      logic [31:0] exp [8] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_00F0, 32'hF000_0000,
                               32'h1234_5678, 32'h8000_0001, 32'h1234_5678, 32'h8000_0000};
      for (int i = 0; i < 8; i++) begin
         issue(4'b0001, 1'b0, 1'b0, ops[i], 32'h0, rms[i], 4'd4);
         checks++; if (ALU_Res !== exp[i]) begin failures++; $display("FAIL shift_%0d got=%h exp=%h", i, ALU_Res, exp[i]); end
      end
   endtask

   task automatic test_logic;
      issue(4'b0110, 1'b0, 1'b1, 12'h0FF, 32'h0000_F0F0, 32'h0, 4'd5);
      checks++; if (ALU_Res !== 32'h0000_00F0) begin failures++; $display("FAIL and_res got=%h exp=000000f0", ALU_Res); end
      issue(4'b0111, 1'b0, 1'b1, 12'h00F, 32'h0000_0F00, 32'h0, 4'd5);
      checks++; if (ALU_Res !== 32'h0000_0F0F) begin failures++; $display("FAIL orr_res got=%h exp=00000f0f", ALU_Res); end
      issue(4'b1000, 1'b1, 1'b1, 12'h0FF, 32'h0000_00FF, 32'h0, 4'd5);
      checks++; if (ALU_Res !== 32'h0) begin failures++; $display("FAIL eor_res got=%h exp=0", ALU_Res); end
      checks++; if (SR !== 4'b0110) begin failures++; $display("FAIL eor_sr got=%b exp=0110", SR); end
   endtask

   task automatic test_sbc;
      issue(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0, 4'd6);
      issue(4'b0101, 1'b1, 1'b1, 12'h003, 32'd10, 32'h0, 4'd6);
      checks++; if (ALU_Res !== 32'd6) begin failures++; $display("FAIL sbc_res got=%h exp=6", ALU_Res); end
      checks++; if (SR !== 4'b0010) begin failures++; $display("FAIL sbc_sr got=%b exp=0010", SR); end
   endtask

   task automatic test_mem_offset;
      MEM_W_EN_IN = 1'b1;
      issue(4'b0010, 1'b0, 1'b1, 12'hFFF, 32'h0000_1000, 32'hDEAD_BEEF, 4'd8);
      MEM_W_EN_IN = 1'b0;
      checks++; if (ALU_Res !== 32'h0000_1FFF) begin failures++; $display("FAIL mem_addr got=%h exp=00001fff", ALU_Res); end
      checks++; if (MEM_W_EN !== 1'b1 || Val_Rm !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mem_store got w=%b rm=%h exp w=1 rm=deadbeef", MEM_W_EN, Val_Rm); end
   endtask

   task automatic test_invalid_cmd;
      issue(4'b1111, 1'b1, 1'b1, 12'h005, 32'd5, 32'h0, 4'd9);
      checks++; if (ALU_Res !== 32'h0) begin failures++; $display("FAIL inv_res got=%h exp=0", ALU_Res); end
      checks++; if (SR !== 4'b0010) begin failures++; $display("FAIL inv_sr got=%b exp=0010", SR); end
   endtask

   task automatic test_branch;
      B_IN = 1'b1; PC_IN = 32'h100; Signed_imm_24_IN = 24'hFFFFFE; #1;
      checks++; if (Br_taken !== 1'b1 || Br_addr !== 32'h0F8) begin failures++; $display("FAIL br_back got t=%b a=%h exp t=1 a=000000f8", Br_taken, Br_addr); end
      flush = 1'b1; #1;
      checks++; if (Br_taken !== 1'b0) begin failures++; $display("FAIL br_flush got=%b exp=0", Br_taken); end
      flush = 1'b0; freeze = 1'b1; PC_IN = 32'h200; Signed_imm_24_IN = 24'h000004; #1;
      checks++; if (Br_taken !== 1'b1 || Br_addr !== 32'h210) begin failures++; $display("FAIL br_fwd got t=%b a=%h exp t=1 a=00000210", Br_taken, Br_addr); end
      freeze = 1'b0; B_IN = 1'b0;
   endtask

   task automatic test_flush;
      MEM_R_EN_IN = 1'b1; flush = 1'b1;
      issue(4'b0010, 1'b1, 1'b1, 12'h001, 32'd1, 32'h0, 4'd10);
      MEM_R_EN_IN = 1'b0; flush = 1'b0;
      checks++; if (WB_EN !== 1'b0 || MEM_R_EN !== 1'b0) begin failures++; $display("FAIL flush_ctl got wb=%b r=%b exp 0 0", WB_EN, MEM_R_EN); end
      checks++; if (ALU_Res !== 32'd2) begin failures++; $display("FAIL flush_data got=%h exp=2", ALU_Res); end
      checks++; if (SR !== 4'b0010) begin failures++; $display("FAIL flush_sr got=%b exp=0010", SR); end
   endtask

   task automatic test_freeze;
      issue(4'b0010, 1'b1, 1'b1, 12'h020, 32'h10, 32'h0, 4'd7);
      checks++; if (ALU_Res !== 32'h30 || SR !== 4'b0000) begin failures++; $display("FAIL frz_setup got res=%h sr=%b exp 30 0000", ALU_Res, SR); end
      freeze = 1'b1;
      for (int c = 0; c < 3; c++) begin
         issue(4'b0100, 1'b1, 1'b1, 12'h001, 32'h0, 32'h0, 4'd9);
         checks++; if (ALU_Res !== 32'h30 || Dest !== 4'd7 || WB_EN !== 1'b1 || SR !== 4'b0000) begin
            failures++; $display("FAIL freeze_hold_%0d got res=%h d=%0d wb=%b sr=%b exp 30 7 1 0000", c, ALU_Res, Dest, WB_EN, SR);
         end
      end
      flush = 1'b1;
      issue(4'b0100, 1'b1, 1'b1, 12'h001, 32'h0, 32'h0, 4'd9);
      checks++; if (WB_EN !== 1'b0 || SR !== 4'b0000) begin failures++; $display("FAIL flush_freeze got wb=%b sr=%b exp 0 0000", WB_EN, SR); end
      flush = 1'b0; freeze = 1'b0;
      issue(4'b0100, 1'b1, 1'b1, 12'h001, 32'h0, 32'h0, 4'd9);
      checks++; if (ALU_Res !== 32'hFFFF_FFFF || SR !== 4'b1000 || Dest !== 4'd9) begin
         failures++; $display("FAIL unfreeze got res=%h sr=%b d=%0d exp ffffffff 1000 9", ALU_Res, SR, Dest);
      end
   endtask

   task automatic test_reset_midstream;
      MEM_W_EN_IN = 1'b1;
      issue(4'b0001, 1'b1, 1'b1, 12'h0AA, 32'h0, 32'h1234_5678, 4'd12);
      MEM_W_EN_IN = 1'b0;
      #3 rst = 1'b0; #1;
      checks++; if (ALU_Res !== 32'h0 || WB_EN !== 1'b0 || MEM_W_EN !== 1'b0 || SR !== 4'b0000 || Dest !== 4'd0 || Val_Rm !== 32'h0) begin
         failures++; $display("FAIL midreset got res=%h wb=%b w=%b sr=%b d=%0d rm=%h exp all 0", ALU_Res, WB_EN, MEM_W_EN, SR, Dest, Val_Rm);
      end
      #1 rst = 1'b1;
      issue(4'b0001, 1'b0, 1'b1, 12'h055, 32'h0, 32'h0, 4'd2);
      checks++; if (ALU_Res !== 32'h55 || WB_EN !== 1'b1 || Dest !== 4'd2) begin
         failures++; $display("FAIL post_reset got res=%h wb=%b d=%0d exp 55 1 2", ALU_Res, WB_EN, Dest);
      end
   endtask

   initial begin
      test_reset;
      test_add_flags;
      test_sub_adc;
      test_imm_rotate;
      test_reg_shift;
      test_logic;
      test_sbc;
      test_mem_offset;
      test_invalid_cmd;
      test_branch;
      test_flush;
      test_freeze;
      test_reset_midstream;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exe_stage_unit.md
# exe_stage_unit

Execute stage of the five-stage ARM-subset pipeline. It consumes the decoded fields that the ID/EXE pipeline register drives and generates the second operand (immediate rotate, shifted register or memory offset). It runs the ALU, keeps the NZCV status register and computes the branch target. Results are registered into the EXE/MEM pipeline register.

## Interface
Parameters:
- WIDTH, 32, datapath width (only 32 is supported)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  squash the instruction currently in EXE
- freeze  in  1  hold all state (output register and status register)
- WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN  in  1 each  decoded controls
- EXE_CMD_IN  in  4  ALU command
- PC_IN  in  32  PC+4 of the instruction
- Val_Rn_IN, Val_Rm_IN  in  32  register operands
- imm_IN  in  1  I bit
- Shift_operand_IN  in  12  shifter operand field
- Signed_imm_24_IN  in  24  branch offset
- Dest_IN  in  4  destination register
- Br_taken  out  1  combinational, equals B_IN & ~flush
- Br_addr  out  32  combinational, PC_IN + (sign-extended Signed_imm_24_IN << 2)
- SR  out  4  status register {N,Z,C,V}
- WB_EN, MEM_R_EN, MEM_W_EN  out  1 each  registered controls
- ALU_Res  out  32  registered ALU result
- Val_Rm  out  32  registered store data
- Dest  out  4  registered destination
- (FWD_EN only) sel_src1, sel_src2  in  2 each; MEM_fwd, WB_fwd  in  32 each

## Operation
- Val2 generation:
  - When MEM_R_EN_IN or MEM_W_EN_IN is set: Val2 = zero-extended Shift_operand_IN.
  - Otherwise, when imm_IN is set: Val2 = {24'b0, Shift_operand_IN[7:0]} rotated right by 2*Shift_operand_IN[11:8].
  - Otherwise: Val_Rm is shifted by Shift_operand_IN[11:7]. The shift type comes from Shift_operand_IN[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- ALU commands on A = Val_Rn, B = Val2, Cin = SR.C:
  - 0001 MOV: B
  - 1001 MVN: ~B
  - 0010 ADD: A+B
  - 0011 ADC: A+B+Cin
  - 0100 SUB: A-B
  - 0101 SBC: A-B-~Cin
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - Any other value returns 0 and leaves the flags unchanged.
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic commands: C is the 33-bit carry out. For subtract, C=1 means no borrow. V is signed overflow.
  - Logic and move commands: C and V keep their current value.
- SR update: at the rising edge when S_IN=1, flush=0 and freeze=0.
- Output register:
  - It loads at each rising edge while freeze=0.
  - When flush=1, WB_EN, MEM_R_EN and MEM_W_EN load 0. The data fields load normally.
- Priority: rst > flush > freeze > normal load.

## Timing
- Reset: all registered outputs and SR read 0 immediately on rst=0.
- ALU_Res, controls, Val_Rm and Dest appear 1 cycle after the inputs are presented.
- SR changes at the same edge. The instruction presented on the next cycle uses the new Cin.
- Br_taken and Br_addr are combinational, with 0-cycle latency. They do not depend on freeze.
- freeze=1: SR and the output register hold their values, including across multiple cycles.
- flush together with freeze: the flush clears the control outputs and SR is not written.
- Reset asserted mid-stream: all state clears. The first edge after release loads normally.
- Arithmetic wraps modulo 2^32. A shift amount of 0 passes Val_Rm unchanged, for every shift type.

## Configuration
- EXE_FWD_EN defined:
  - The sel_src1/sel_src2 muxes are compiled in, ahead of Val2 generation and ahead of the ALU.
  - Select encoding: 00 selects the ID value, 01 selects MEM_fwd, 10 selects WB_fwd, 11 is reserved (behaves as 00).
  - sel_src2 also selects the Val_Rm store data.
- EXE_FWD_EN undefined: the forwarding ports are absent and the operands come straight from Val_Rn_IN and Val_Rm_IN.

## Test plan
- Reset: rst=0 mid-operation -> ALU_Res=0, WB_EN=0, SR=0000 with no clock edge.
- ADD with flags: Rn=0x7FFFFFFF, imm_IN=1, operand 0x001, S=1 -> ALU_Res=0x80000000 next cycle; SR N=1,Z=0,C=0,V=1.
- Subtract then carry chain:
  - SUB with Rn=5, Val2=5, S=1 -> result 0, SR Z=1, C=1.
  - The next instruction, ADC with Rn=1, Val2=1 -> result 3.
- Immediate rotate: operand 0x4FF -> Val2=0xFF000000.
- Register shift: Rm=0x80000000 with ASR #4 -> Val2=0xF8000000.
- Branch with flush and freeze:
  - B with PC_IN=0x100 and imm24=0xFFFFFE -> Br_addr=0x0F8.
  - flush=1 alongside S=1 -> SR unchanged and WB_EN=0.
  - freeze=1 for 3 cycles -> outputs are stable throughout.
